demux_select_sequencer: RTL and testbench

- Control stage directly upstream of the 1:N DEMUX tree (1:2 up to 1:16).
- Accepts a serial bit stream over a valid/ready handshake.
- Drives the DEMUX's enable, data and select lines, registered, so that bursts of bits are steered to channels in round-robin or fixed-channel order.
- Marks the end of each frame with a one-cycle done pulse.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_channel_counter.sv | 77 +++++++
 rtl/demux_select_sequencer.sv | 121 ++++++++++++
 tb/tb_demux_select_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the DEMUX select sequencer and the DEMUX tree it drives.
// Holds the FSM encoding, the steering modes and the default channel geometry.
package demux_pkg;

    localparam int DEFAULT_NUM_CHANNELS = 16;
    localparam int DEFAULT_SEL_WIDTH    = 4;
    localparam int DEFAULT_BURST_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ROUND_ROBIN = 1'b0;
    localparam logic MODE_FIXED       = 1'b1;

endpackage

// File: rtl/demux_channel_counter.sv
// Bit, burst and channel bookkeeping for one frame.
// frame_last_o flags that an accepted bit right now would complete the frame.
module demux_channel_counter
    import demux_pkg::*;
#(
    parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
    parameter int SEL_WIDTH    = DEFAULT_SEL_WIDTH,
    parameter int BURST_WIDTH  = DEFAULT_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic                   advance_i,
    input  logic                   mode_i,
    input  logic [SEL_WIDTH-1:0]   start_channel_i,
    input  logic [BURST_WIDTH-1:0] burst_len_i,
    output logic [SEL_WIDTH-1:0]   channel_o,
    output logic                   frame_last_o
);

    localparam int CNT_W = SEL_WIDTH + 1;
    localparam logic [SEL_WIDTH-1:0]   LAST_CHANNEL = SEL_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0]       LAST_BURST   = CNT_W'(NUM_CHANNELS - 1);
    localparam logic [SEL_WIDTH-1:0]   SEL_ONE      = SEL_WIDTH'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
    localparam logic [BURST_WIDTH-1:0] BIT_ONE      = BURST_WIDTH'(1);

    logic [BURST_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [SEL_WIDTH-1:0]   channel_q, channel_d;
    logic                   burst_end;

    // burst_len_i is never zero while bits are flowing, so the subtraction cannot wrap.
    assign burst_end    = (bit_cnt_q == burst_len_i - BIT_ONE);
    assign frame_last_o = burst_end & ((mode_i == MODE_FIXED) | (burst_cnt_q == LAST_BURST));
    assign channel_o    = channel_q;

    always_comb begin
        // NOTE: defaults first so every path assigns each _d signal and no latch is inferred.
        bit_cnt_d   = bit_cnt_q;
        burst_cnt_d = burst_cnt_q;
        channel_d   = channel_q;
        if (load_i) begin
            bit_cnt_d   = '0;
            burst_cnt_d = '0;
            channel_d   = start_channel_i;
        end else if (clear_i) begin
            bit_cnt_d   = '0;
            burst_cnt_d = '0;
        end else if (advance_i) begin
            if (burst_end) begin
                bit_cnt_d   = '0;
                burst_cnt_d = burst_cnt_q + CNT_ONE;
                if (mode_i == MODE_ROUND_ROBIN) begin
                    channel_d = (channel_q == LAST_CHANNEL) ? '0 : channel_q + SEL_ONE;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            burst_cnt_q <= '0;
            channel_q   <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            channel_q   <= channel_d;
        end
    end

endmodule

// File: rtl/demux_select_sequencer.sv
// Control stage in front of a 1:N DEMUX tree: accepts a serial bit stream and
// drives registered enable/data/select so bursts are steered round-robin or to one channel.
module demux_select_sequencer
    import demux_pkg::*;
#(
    parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
    parameter int SEL_WIDTH    = DEFAULT_SEL_WIDTH,
    parameter int BURST_WIDTH  = DEFAULT_BURST_WIDTH
) (
    input  logic                   Clock_In,
    input  logic                   Reset_n_In,
    input  logic                   Start_In,
    input  logic                   Abort_In,
    input  logic                   Mode_In,
    input  logic [SEL_WIDTH-1:0]   Channel_In,
    input  logic [BURST_WIDTH-1:0] Burst_Length_In,
    input  logic                   Data_Valid_In,
    input  logic                   Data_In,
    output logic                   Data_Ready_Out,
    output logic                   Enable_Out,
    output logic                   Data_Out,
    output logic [SEL_WIDTH-1:0]   Select_Out,
    output logic                   Busy_Out,
    output logic                   Frame_Done_Out
);

    if (NUM_CHANNELS < 2 || (2 ** SEL_WIDTH) < NUM_CHANNELS) begin : g_bad_params
        $error("demux_select_sequencer: SEL_WIDTH too narrow for NUM_CHANNELS");
    end

    localparam int SEL_W1 = SEL_WIDTH + 1;
    localparam logic [SEL_W1-1:0] CHANNEL_LIMIT = SEL_W1'(NUM_CHANNELS);

    state_t                 state_q;
    logic                   mode_q;
    logic [BURST_WIDTH-1:0] burst_len_q;
    logic                   enable_q, data_q, busy_q, done_q;
    logic [SEL_WIDTH-1:0]   sel_q;

    logic                   start_ok, transfer, frame_last;
    logic [SEL_WIDTH-1:0]   start_channel, channel;

    assign start_ok      = (state_q == ST_IDLE) & Start_In & ~Abort_In & (Burst_Length_In != '0);
    assign start_channel = ({1'b0, Channel_In} >= CHANNEL_LIMIT) ? '0 : Channel_In;

    // Ready falls as soon as the final bit moves the FSM to DONE, and in any abort cycle.
    assign Data_Ready_Out = (state_q == ST_RUN) & ~Abort_In;
    assign transfer       = Data_Valid_In & Data_Ready_Out;

    demux_channel_counter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .SEL_WIDTH    (SEL_WIDTH),
        .BURST_WIDTH  (BURST_WIDTH)
    ) u_counter (
        .clk             (Clock_In),
        .rst_n           (Reset_n_In),
        .load_i          (start_ok),
        .clear_i         (Abort_In & (state_q != ST_IDLE)),
        .advance_i       (transfer),
        .mode_i          (mode_q),
        .start_channel_i (start_channel),
        .burst_len_i     (burst_len_q),
        .channel_o       (channel),
        .frame_last_o    (frame_last)
    );

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ROUND_ROBIN;
            burst_len_q <= '0;
            enable_q    <= 1'b0;
            data_q      <= 1'b0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Select and data hold between accepted bits; only enable drops.
            enable_q <= transfer;
            if (transfer) begin
                data_q <= Data_In;
                sel_q  <= channel;
            end
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q     <= ST_RUN;
                        mode_q      <= Mode_In;
                        burst_len_q <= Burst_Length_In;
                        busy_q      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (Abort_In) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (transfer && frame_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Enable_Out     = enable_q;
    assign Data_Out       = data_q;
    assign Select_Out     = sel_q;
    assign Busy_Out       = busy_q;
    assign Frame_Done_Out = done_q;

endmodule

// File: tb/tb_demux_select_sequencer.sv
// Scoreboard bench: the driver predicts each steered bit from a frame plan
// (list of selects) and a separate negedge monitor pops and compares.
module tb_demux_select_sequencer;

    localparam int N  = 6;
    localparam int SW = 3;
    localparam int BW = 4;

    logic          Clock_In = 1'b0;
    logic          Reset_n_In = 1'b1;
    logic          Start_In = 1'b0;
    logic          Abort_In = 1'b0;
    logic          Mode_In = 1'b0;
    logic [SW-1:0] Channel_In = '0;
    logic [BW-1:0] Burst_Length_In = '0;
    logic          Data_Valid_In = 1'b0;
    logic          Data_In = 1'b0;
    logic          Data_Ready_Out, Enable_Out, Data_Out, Busy_Out, Frame_Done_Out;
    logic [SW-1:0] Select_Out;

    demux_select_sequencer #(
        .NUM_CHANNELS (N),
        .SEL_WIDTH    (SW),
        .BURST_WIDTH  (BW)
    ) dut (
        .Clock_In        (Clock_In),
        .Reset_n_In      (Reset_n_In),
        .Start_In        (Start_In),
        .Abort_In        (Abort_In),
        .Mode_In         (Mode_In),
        .Channel_In      (Channel_In),
        .Burst_Length_In (Burst_Length_In),
        .Data_Valid_In   (Data_Valid_In),
        .Data_In         (Data_In),
        .Data_Ready_Out  (Data_Ready_Out),
        .Enable_Out      (Enable_Out),
        .Data_Out        (Data_Out),
        .Select_Out      (Select_Out),
        .Busy_Out        (Busy_Out),
        .Frame_Done_Out  (Frame_Done_Out)
    );

    always #5 Clock_In = ~Clock_In;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: frame plan = ordered list of selects for every bit of the frame.
    bit   m_run = 0;
    bit   m_done = 0;
    int   plan[$];
    int   m_idx = 0;

    logic [SW-1:0] last_sel = '0;
    logic          last_data = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic build_plan(input bit mode, input logic [SW-1:0] ch, input logic [BW-1:0] len);
        int first;
        int bursts;
        first  = (int'(ch) >= N) ? 0 : int'(ch);
        bursts = mode ? 1 : N;
        plan.delete();
        for (int b = 0; b < bursts; b++)
            for (int k = 0; k < int'(len); k++)
                plan.push_back((first + b) % N);
        m_idx = 0;
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic cycle(input bit start, input bit abort, input bit valid, input bit din,
                         input bit mode, input logic [SW-1:0] ch, input logic [BW-1:0] len);
        exp_t e;
        bit   xfer;
        bit   was_run, was_done;
        Start_In = start; Abort_In = abort; Data_Valid_In = valid; Data_In = din;
        Mode_In = mode; Channel_In = ch; Burst_Length_In = len;
        #1;
        check("ready", Data_Ready_Out, m_run && !abort);
        check("busy", Busy_Out, m_run || m_done);
        xfer = 0;
        e = '0;
        was_run = m_run;
        was_done = m_done;
        if (was_run) begin
            if (abort) begin
                m_run = 0;
            end else if (valid) begin
                xfer   = 1;
                e.sel  = SW'(plan[m_idx]);
                e.data = din;
                m_idx++;
                e.last = (m_idx == plan.size());
                if (e.last) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end else if (was_done) begin
            m_done = 0;
        end else if (start && !abort && len != 0) begin
            build_plan(mode, ch, len);
            m_run = 1;
        end
        @(posedge Clock_In);
        if (xfer) exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0, '0);
    endtask

    // valid_pct < 0 means valid on every other cycle.
    task automatic run_frame(input bit mode, input logic [SW-1:0] ch, input logic [BW-1:0] len,
                             input int valid_pct, input int abort_pct);
        int budget;
        int k;
        bit v, a;
        cycle(1, 0, 0, 0, mode, ch, len);
        budget = 400;
        k = 0;
        while ((m_run || m_done) && budget > 0) begin
            v = (valid_pct < 0) ? (k % 2 == 1) : ($urandom_range(0, 99) < valid_pct);
            a = ($urandom_range(0, 99) < abort_pct);
            cycle(bit'($urandom_range(0, 1)), a, v, bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), SW'($urandom_range(0, 7)), BW'($urandom()));
            k++;
            budget--;
        end
        check("frame_ends_within_budget", m_run || m_done, 0);
        idle(1);
    endtask

    always @(negedge Clock_In) begin : monitor
        exp_t e;
        bit   exp_en;
        if (Reset_n_In) begin
            exp_en = (exp_q.size() != 0);
            check("enable", Enable_Out, exp_en);
            if (exp_en) begin
                e = exp_q.pop_front();
                if (Enable_Out) begin
                    check("select", Select_Out, e.sel);
                    check("data", Data_Out, e.data);
                    check("frame_done", Frame_Done_Out, e.last);
                end
                last_sel  = e.sel;
                last_data = e.data;
            end else begin
                check("hold_select", Select_Out, last_sel);
                check("hold_data", Data_Out, last_data);
                check("frame_done_idle", Frame_Done_Out, 0);
            end
        end
    end

    task automatic reset_outputs_check(input string tag);
        check({tag, "_enable"}, Enable_Out, 0);
        check({tag, "_data"}, Data_Out, 0);
        check({tag, "_select"}, Select_Out, 0);
        check({tag, "_busy"}, Busy_Out, 0);
        check({tag, "_done"}, Frame_Done_Out, 0);
        check({tag, "_ready"}, Data_Ready_Out, 0);
    endtask

    initial begin
        #1 Reset_n_In = 1'b0;
        #1 reset_outputs_check("por");
        @(posedge Clock_In); #1;
        @(posedge Clock_In); #1;
        Reset_n_In = 1'b1;
        idle(2);

        // Fixed channel 5, burst 3, bits 1,0,1 with valid held high throughout.
        cycle(1, 0, 1, 0, 1, 3'd5, 4'd3);
        cycle(0, 0, 1, 1, 0, 3'd0, 4'd0);
        cycle(0, 0, 1, 0, 0, 3'd0, 4'd0);
        cycle(0, 0, 1, 1, 0, 3'd0, 4'd0);
        cycle(0, 0, 1, 0, 0, 3'd0, 4'd0);
        idle(2);

        // Round-robin from channel 2, burst 2: selects 2,2,3,3,4,4,5,5,0,0,1,1.
        run_frame(0, 3'd2, 4'd2, 100, 0);
        // Gapped valid, fixed mode, burst 4.
        run_frame(1, 3'd4, 4'd4, -1, 0);

        // Abort on the 2nd bit of a burst-4 frame, then a normal frame.
        cycle(1, 0, 0, 0, 1, 3'd1, 4'd4);
        cycle(0, 0, 1, 1, 0, 3'd0, 4'd0);
        cycle(0, 1, 1, 0, 0, 3'd0, 4'd0);
        idle(2);
        run_frame(1, 3'd1, 4'd4, 100, 0);

        // Zero burst length and start+abort together are both ignored.
        cycle(1, 0, 1, 1, 0, 3'd2, 4'd0);
        idle(1);
        cycle(1, 1, 1, 1, 1, 3'd2, 4'd3);
        idle(1);

        // Out-of-range channels fall back to 0.
        run_frame(1, 3'd7, 4'd2, 100, 0);
        run_frame(0, 3'd6, 4'd1, 80, 0);

        for (int f = 0; f < 10; f++) begin
            bit            md;
            logic [BW-1:0] ln;
            md = bit'($urandom_range(0, 1));
            ln = md ? BW'($urandom_range(1, 15)) : BW'($urandom_range(1, 3));
            run_frame(md, SW'($urandom_range(0, 7)), ln, 70, 3);
        end

        // Asynchronous reset in the middle of a frame, between clock edges.
        cycle(1, 0, 0, 0, 1, 3'd3, 4'd4);
        cycle(0, 0, 1, 1, 0, 3'd0, 4'd0);
        cycle(0, 0, 1, 1, 0, 3'd0, 4'd0);
        #2;
        Reset_n_In = 1'b0;
        exp_q.delete();
        m_run = 0;
        m_done = 0;
        last_sel = '0;
        last_data = 1'b0;
        #1 reset_outputs_check("mid_run_reset");
        @(posedge Clock_In);
        @(posedge Clock_In); #1;
        Reset_n_In = 1'b1;
        idle(2);
        run_frame(0, 3'd0, 4'd1, 100, 0);

        idle(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
